// File: rtl/i_pixel_writer_if.sv
// Pixel stream and memory write bus for i_pixel_writer.
// master = the writer itself, slave = the upstream source plus the memory it writes to.
interface i_pixel_writer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 24
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        input  pix_valid, pix_data, mem_ack,
        output pix_ready, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output pix_valid, pix_data, mem_ack,
        input  pix_ready, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/i_pixel_writer.sv
// Writes one frame of pixels to linear memory starting at base_addr.
// One pixel per write; the address advances by incrementing, never by multiplying.
module i_pixel_writer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 24
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [12:0]           img_width,
    input  logic [12:0]           img_height,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic [12:0]           col,
    output logic [12:0]           row,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err,
    i_pixel_writer_if.master      bus
);
    localparam int unsigned DIM_W = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cfg_err_q, cfg_err_d;
    logic              last_col;
    logic              last_row;

    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_row = (row_q == height_q - DIM_W'(1));

    // State register and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state and datapath update; abort overrides every other input
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cfg_err_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if ((img_width != '0) && (img_height != '0)) begin
                            width_d  = img_width;
                            height_d = img_height;
                            col_d    = '0;
                            row_d    = '0;
                            addr_d   = base_addr;
                            state_d  = ACCEPT;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (bus.pix_valid) begin
                        wdata_d = bus.pix_data;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        if (last_col && last_row) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ACCEPT;
                            if (last_col) begin
                                col_d = '0;
                                row_d = row_q + DIM_W'(1);
                            end else begin
                                col_d = col_q + DIM_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state so reset clears them immediately
    assign bus.pix_ready = (state_q == ACCEPT);
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign col           = col_q;
    assign row           = row_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_i_pixel_writer.sv
// Directed self-checking bench for i_pixel_writer.
module tb_i_pixel_writer;
    logic        clk;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [12:0] img_width;
    logic [12:0] img_height;
    logic [23:0] base_addr;
    logic [12:0] col;
    logic [12:0] row;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd_base;

    i_pixel_writer_if #(.DATA_W(8), .ADDR_W(24)) bus ();

    i_pixel_writer #(.DATA_W(8), .ADDR_W(24)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .base_addr  (base_addr),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [12:0] w, input logic [12:0] h, input logic [23:0] b);
        start = 1'b1; img_width = w; img_height = h; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feed one pixel, hold ack low for stall cycles, then ack for one cycle
    task automatic px(input logic [7:0] d, input logic [23:0] ea, input int ec, input int er, input int stall);
        bus.pix_valid = 1'b1; bus.pix_data = d;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("wr_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("wr_addr", 32'(bus.mem_addr), 32'(ea));
        chk("wr_wdata", 32'(bus.mem_wdata), 32'(d));
        chk("wr_col", 32'(col), 32'(ec));
        chk("wr_row", 32'(row), 32'(er));
        chk("wr_pix_ready", 32'(bus.pix_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_mem_wr", 32'(bus.mem_wr), 32'd1);
            chk("stall_addr", 32'(bus.mem_addr), 32'(ea));
            chk("stall_wdata", 32'(bus.mem_wdata), 32'(d));
            chk("stall_pix_ready", 32'(bus.pix_ready), 32'd0);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        img_width = '0; img_height = '0; base_addr = '0;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // 3x2 frame at 0x100, with stray start/ack while accepting
        fd_base = fd_cnt;
        start_frame(13'd3, 13'd2, 24'h000100);
        chk("f1_busy", 32'(busy), 32'd1);
        chk("f1_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("f1_addr0", 32'(bus.mem_addr), 32'h100);
        px(8'hA0, 24'h000100, 0, 0, 1);
        start = 1'b1; img_width = 13'd7; img_height = 13'd7; base_addr = 24'h000500;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.mem_ack = 1'b0;
        chk("ign_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("ign_addr", 32'(bus.mem_addr), 32'h101);
        chk("ign_col", 32'(col), 32'd1);
        px(8'hA1, 24'h000101, 1, 0, 1);
        px(8'hA2, 24'h000102, 2, 0, 1);
        px(8'hA3, 24'h000103, 0, 1, 1);
        px(8'hA4, 24'h000104, 1, 1, 1);
        px(8'hA5, 24'h000105, 2, 1, 1);
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_done_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("f1_done_addr", 32'(bus.mem_addr), 32'h105);
        @(negedge clk);
        chk("f1_done_off", 32'(frame_done), 32'd0);
        chk("f1_idle", 32'(busy), 32'd0);
        chk("f1_done_count", 32'(fd_cnt - fd_base), 32'd1);

        // Long ack stall on a 2x1 frame
        start_frame(13'd2, 13'd1, 24'h000020);
        px(8'h55, 24'h000020, 0, 0, 5);
        px(8'h66, 24'h000021, 1, 0, 0);
        chk("f2_done", 32'(frame_done), 32'd1);
        @(negedge clk);
        chk("f2_idle", 32'(busy), 32'd0);

        // Zero-dimension starts
        start_frame(13'd0, 13'd5, 24'h000010);
        chk("cfgw_err", 32'(cfg_err), 32'd1);
        chk("cfgw_busy", 32'(busy), 32'd0);
        chk("cfgw_mem_wr", 32'(bus.mem_wr), 32'd0);
        @(negedge clk);
        chk("cfgw_err_off", 32'(cfg_err), 32'd0);
        chk("cfgw_busy2", 32'(busy), 32'd0);
        start_frame(13'd4, 13'd0, 24'h000010);
        chk("cfgh_err", 32'(cfg_err), 32'd1);
        chk("cfgh_busy", 32'(busy), 32'd0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; img_width = 13'd4; img_height = 13'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        chk("abst_cfg_err", 32'(cfg_err), 32'd0);

        // Abort mid-WRITE of pixel 2 in a 4x4 frame, then restart
        fd_base = fd_cnt;
        start_frame(13'd4, 13'd4, 24'h000040);
        px(8'h10, 24'h000040, 0, 0, 1);
        px(8'h11, 24'h000041, 1, 0, 1);
        bus.pix_valid = 1'b1; bus.pix_data = 8'h12;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("ab_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("ab_addr", 32'(bus.mem_addr), 32'h42);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_mem_wr_off", 32'(bus.mem_wr), 32'd0);
        chk("ab_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("ab_done_count", 32'(fd_cnt - fd_base), 32'd0);
        start_frame(13'd4, 13'd4, 24'h000040);
        chk("rs_col", 32'(col), 32'd0);
        chk("rs_row", 32'(row), 32'd0);
        chk("rs_addr", 32'(bus.mem_addr), 32'h40);
        chk("rs_pix_ready", 32'(bus.pix_ready), 32'd1);
        px(8'h20, 24'h000040, 0, 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("rs_abort_busy", 32'(busy), 32'd0);

        // Width 1 with address wrap past 2^24
        start_frame(13'd1, 13'd3, 24'hFFFFFE);
        px(8'h01, 24'hFFFFFE, 0, 0, 1);
        px(8'h02, 24'hFFFFFF, 0, 1, 1);
        px(8'h03, 24'h000000, 0, 2, 1);
        chk("wrap_done", 32'(frame_done), 32'd1);
        chk("wrap_addr", 32'(bus.mem_addr), 32'h0);
        @(negedge clk);
        chk("wrap_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-WRITE
        start_frame(13'd2, 13'd2, 24'h000300);
        bus.pix_valid = 1'b1; bus.pix_data = 8'h77;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("ar_pre_mem_wr", 32'(bus.mem_wr), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("ar_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("ar_addr", 32'(bus.mem_addr), 32'd0);
        chk("ar_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("ar_col", 32'(col), 32'd0);
        chk("ar_row", 32'(row), 32'd0);
        chk("ar_frame_done", 32'(frame_done), 32'd0);
        chk("ar_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        bus.pix_valid = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.pix_valid = 1'b0; bus.mem_ack = 1'b0;
        chk("ar_after_busy", 32'(busy), 32'd0);
        chk("ar_after_mem_wr", 32'(bus.mem_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
